// File: rtl/vga_rd_pos_tracker.sv
// Frame-buffer read position tracker for the VGA output path.
// Delays READ_Request by RD_LAT cycles so DVAL lines up with pixel data
// leaving the frame buffer, then tracks column, line and frame counts.
// It also provides line/frame strobes, last-pixel and window flags, and
// sticky overrun flags for lines and frames that run long.
module vga_rd_pos_tracker #(
  parameter int XW         = 11,
  parameter int YW         = 11,
  parameter int FW         = 8,
  parameter int RD_LAT     = 1,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int VS_ACT_LOW = 1
) (
  input  logic          VGA_CLK,
  input  logic          RESET_N,
  input  logic          VGA_VS,
  input  logic          READ_Request,
  input  logic [XW-1:0] WIN_X0,
  input  logic [XW-1:0] WIN_X1,
  input  logic [YW-1:0] WIN_Y0,
  input  logic [YW-1:0] WIN_Y1,
  output logic          DVAL,
  output logic [XW-1:0] X_Cont,
  output logic [YW-1:0] Y_Cont,
  output logic [FW-1:0] Frame_Cont,
  output logic          Frame_Start,
  output logic          Line_End,
  output logic          Last_Pix,
  output logic          In_Win,
  output logic          X_Over,
  output logic          Y_Over
);

  // VGA_VS level that means "vertical sync asserted".
  localparam logic VS_LEVEL = (VS_ACT_LOW == 0);

  // First column / line index that counts as an overrun, and the last
  // expected column / line of a frame.
  localparam logic [XW-1:0] X_LIMIT = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LIMIT = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);

  // Counters stop at all-ones rather than wrapping back into valid range.
  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (&v) ? v : v + XW'(1);
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (&v) ? v : v + YW'(1);
  endfunction

  logic              vs_act;
  logic              vs_act_p1;
  logic              vs_rise;
  logic [RD_LAT-1:0] rd_dly_p;
  logic [RD_LAT-1:0] rd_dly_nx;
  logic              dval_nx;
  logic              line_end_nx;
  logic [YW-1:0]     y_inc;
  logic              win_x_ok;
  logic              win_y_ok;

  assign vs_act  = (VGA_VS == VS_LEVEL);
  assign vs_rise = vs_act & ~vs_act_p1;

  // Shift the request in at bit 0; the cast drops the stage that falls off
  // the end (that stage is DVAL itself). Written this way so RD_LAT=1 needs
  // no special case.
  assign rd_dly_nx = RD_LAT'({rd_dly_p, READ_Request});
  assign dval_nx   = rd_dly_nx[RD_LAT-1];
  assign DVAL      = rd_dly_p[RD_LAT-1];

  // A line ends on the first cycle DVAL is low after being high; a VS
  // activation on the same edge takes priority and suppresses it.
  assign line_end_nx = DVAL & ~dval_nx & ~vs_act;
  assign y_inc       = sat_inc_y(Y_Cont);

  // ---- stage p0 -> p1: VS edge detect ----
  // Registered copy of vs_act so only the first active cycle starts a frame.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) vs_act_p1 <= 1'b0;
    else          vs_act_p1 <= vs_act;
  end

  // ---- read-latency pipeline ----
  // Requests in flight are flushed whenever VS is active.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N)    rd_dly_p <= '0;
    else if (vs_act) rd_dly_p <= '0;
    else             rd_dly_p <= rd_dly_nx;
  end

  // Column counter: 0 on the first valid pixel of a run, +1 per consecutive
  // valid pixel, back to 0 as soon as DVAL drops.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N)                X_Cont <= '0;
    else if (vs_act)             X_Cont <= '0;
    else if (dval_nx && DVAL)    X_Cont <= sat_inc_x(X_Cont);
    else                         X_Cont <= '0;
  end

  // Line counter and line-end strobe, both updated on the DVAL falling edge.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Y_Cont   <= '0;
      Line_End <= 1'b0;
    end else begin
      Line_End <= line_end_nx;
      if (vs_act)           Y_Cont <= '0;
      else if (line_end_nx) Y_Cont <= y_inc;
    end
  end

  // Frame counter and frame-start strobe on VS activation; wraps at 2^FW.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Frame_Cont  <= '0;
      Frame_Start <= 1'b0;
    end else begin
      Frame_Start <= vs_rise;
      if (vs_rise) Frame_Cont <= Frame_Cont + FW'(1);
    end
  end

  // Sticky overrun flags; a new frame clears them, which wins over a
  // same-edge set.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      X_Over <= 1'b0;
      Y_Over <= 1'b0;
    end else if (vs_rise) begin
      X_Over <= 1'b0;
      Y_Over <= 1'b0;
    end else begin
      if (DVAL && (X_Cont >= X_LIMIT))      X_Over <= 1'b1;
      if (line_end_nx && (y_inc > Y_LIMIT)) Y_Over <= 1'b1;
    end
  end

  // Window and last-pixel decode straight off the registered position.
  // An inverted window (X0>X1 or Y0>Y1) can never match.
  always_comb begin
    win_x_ok = (WIN_X0 <= WIN_X1) && (X_Cont >= WIN_X0) && (X_Cont <= WIN_X1);
    win_y_ok = (WIN_Y0 <= WIN_Y1) && (Y_Cont >= WIN_Y0) && (Y_Cont <= WIN_Y1);
    In_Win   = DVAL && win_x_ok && win_y_ok;
    Last_Pix = DVAL && (X_Cont == X_LAST) && (Y_Cont == Y_LAST);
  end

endmodule

// File: tb/tb_vga_rd_pos_tracker.sv
// Directed bench for vga_rd_pos_tracker. Two instances share stimulus:
// dut_a uses RD_LAT=3 with active-low VS; dut_b uses RD_LAT=1, FW=2 with
// active-high VS (driven with the inverted sync). Small H/V sizes keep
// full frames short.
module tb_vga_rd_pos_tracker;

  localparam int H = 16;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs_a;
  logic        vs_b;
  logic        req;
  logic [10:0] wx0, wx1, wy0, wy1;

  logic        dval_a, fs_a, le_a, lp_a, iw_a, xo_a, yo_a;
  logic [10:0] x_a, y_a;
  logic [7:0]  fc_a;
  logic        dval_b, fs_b, le_b, lp_b, iw_b, xo_b, yo_b;
  logic [10:0] x_b, y_b;
  logic [1:0]  fc_b;

  always #5 clk = ~clk;
  assign vs_b = ~vs_a;

  vga_rd_pos_tracker #(
    .XW(11), .YW(11), .FW(8), .RD_LAT(3), .H_ACTIVE(H), .V_ACTIVE(V), .VS_ACT_LOW(1)
  ) dut_a (
    .VGA_CLK(clk), .RESET_N(rst_n), .VGA_VS(vs_a), .READ_Request(req),
    .WIN_X0(wx0), .WIN_X1(wx1), .WIN_Y0(wy0), .WIN_Y1(wy1),
    .DVAL(dval_a), .X_Cont(x_a), .Y_Cont(y_a), .Frame_Cont(fc_a),
    .Frame_Start(fs_a), .Line_End(le_a), .Last_Pix(lp_a), .In_Win(iw_a),
    .X_Over(xo_a), .Y_Over(yo_a)
  );

  vga_rd_pos_tracker #(
    .XW(11), .YW(11), .FW(2), .RD_LAT(1), .H_ACTIVE(H), .V_ACTIVE(V), .VS_ACT_LOW(0)
  ) dut_b (
    .VGA_CLK(clk), .RESET_N(rst_n), .VGA_VS(vs_b), .READ_Request(req),
    .WIN_X0(wx0), .WIN_X1(wx1), .WIN_Y0(wy0), .WIN_Y1(wy1),
    .DVAL(dval_b), .X_Cont(x_b), .Y_Cont(y_b), .Frame_Cont(fc_b),
    .Frame_Start(fs_b), .Line_End(le_b), .Last_Pix(lp_b), .In_Win(iw_b),
    .X_Over(xo_b), .Y_Over(yo_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Event counters sampled on the falling edge; clr zeroes them.
  logic clr = 1'b0;
  int win_a, win_b, last_a, last_b, le_cnt_a, dv_cnt_a, dv_cnt_b;

  always @(negedge clk) begin
    if (clr) begin
      win_a <= 0; win_b <= 0; last_a <= 0; last_b <= 0;
      le_cnt_a <= 0; dv_cnt_a <= 0; dv_cnt_b <= 0;
    end else begin
      win_a    <= win_a + int'(iw_a);
      win_b    <= win_b + int'(iw_b);
      last_a   <= last_a + int'(lp_a);
      last_b   <= last_b + int'(lp_b);
      le_cnt_a <= le_cnt_a + int'(le_a);
      dv_cnt_a <= dv_cnt_a + int'(dval_a);
      dv_cnt_b <= dv_cnt_b + int'(dval_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  // Two-cycle VS assertion; Frame_Start must pulse exactly once.
  task automatic vs_pulse();
    vs_a = 1'b0;
    step();
    chk("fs_a_pulse", fs_a, 1);
    chk("fs_b_pulse", fs_b, 1);
    step();
    chk("fs_a_once", fs_a, 0);
    vs_a = 1'b1;
  endtask

  task automatic run_line(input int n, input int gap);
    req = 1'b1;
    repeat (n) step();
    req = 1'b0;
    repeat (gap) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vs_a = 1'b1; req = 1'b0;
    wx0 = 11'd3; wx1 = 11'd6; wy0 = 11'd1; wy1 = 11'd2;
    repeat (3) step();
    chk("rst_dval_a", dval_a, 0);
    chk("rst_x_a", x_a, 0);
    chk("rst_y_a", y_a, 0);
    chk("rst_fc_a", fc_a, 0);
    chk("rst_fs_a", fs_a, 0);
    chk("rst_le_a", le_a, 0);
    chk("rst_xo_a", xo_a, 0);
    chk("rst_yo_a", yo_a, 0);
    chk("rst_fc_b", fc_b, 0);
    chk("rst_dval_b", dval_b, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Frame 1: detailed latency/position trace of the first line.
    clr_cnt();
    vs_pulse();
    chk("f1_fc_a", fc_a, 1);
    chk("f1_fc_b", fc_b, 1);
    req = 1'b1;
    step();
    chk("lat_dval_b_c1", dval_b, 1);
    chk("lat_x_b_c1", x_b, 0);
    chk("lat_dval_a_c1", dval_a, 0);
    step();
    chk("lat_dval_a_c2", dval_a, 0);
    chk("lat_x_b_c2", x_b, 1);
    step();
    chk("lat_dval_a_c3", dval_a, 1);
    chk("lat_x_a_c3", x_a, 0);
    chk("lat_x_b_c3", x_b, 2);
    repeat (13) step();
    req = 1'b0;
    chk("l1_x_a_13", x_a, 13);
    chk("l1_x_b_15", x_b, 15);
    step();
    chk("l1_le_b", le_b, 1);
    chk("l1_y_b", y_b, 1);
    chk("l1_dval_b_low", dval_b, 0);
    chk("l1_x_b_zero", x_b, 0);
    chk("l1_x_a_14", x_a, 14);
    chk("l1_le_a_early", le_a, 0);
    step();
    chk("l1_x_a_15", x_a, 15);
    chk("l1_le_b_once", le_b, 0);
    chk("l1_lp_a_row0", lp_a, 0);
    step();
    chk("l1_le_a", le_a, 1);
    chk("l1_y_a", y_a, 1);
    chk("l1_dval_a_low", dval_a, 0);
    repeat (3) step();
    repeat (V - 1) run_line(H, 5);
    chk("f1_y_a", y_a, V);
    chk("f1_y_b", y_b, V);
    chk("f1_xo_a", xo_a, 0);
    chk("f1_yo_a", yo_a, 0);
    chk("f1_yo_b", yo_b, 0);
    chk("f1_win_a", win_a, 8);
    chk("f1_win_b", win_b, 8);
    chk("f1_last_a", last_a, 1);
    chk("f1_last_b", last_b, 1);
    chk("f1_le_cnt_a", le_cnt_a, V);

    // Frame 2: inverted X window never matches.
    wx0 = 11'd6; wx1 = 11'd3;
    clr_cnt();
    vs_pulse();
    chk("f2_fc_a", fc_a, 2);
    chk("f2_fc_b", fc_b, 2);
    repeat (V) run_line(H, 5);
    chk("f2_win_a", win_a, 0);
    chk("f2_win_b", win_b, 0);
    chk("f2_last_a", last_a, 1);
    wx0 = 11'd3; wx1 = 11'd6;

    // Frame 3: one long line, then too many lines.
    vs_pulse();
    chk("f3_fc_b", fc_b, 3);
    run_line(H + 2, 5);
    chk("ov_xo_a", xo_a, 1);
    chk("ov_xo_b", xo_b, 1);
    chk("ov_yo_a_early", yo_a, 0);
    chk("ov_y_a_1", y_a, 1);
    repeat (V - 1) run_line(H, 5);
    chk("ov_y_a_v", y_a, V);
    chk("ov_yo_a_at_v", yo_a, 0);
    run_line(H, 5);
    chk("ov_y_a_v1", y_a, V + 1);
    chk("ov_yo_a_set", yo_a, 1);
    chk("ov_yo_b_set", yo_b, 1);
    run_line(H, 5);
    chk("ov_y_a_v2", y_a, V + 2);
    chk("ov_yo_a_sticky", yo_a, 1);
    chk("ov_xo_a_sticky", xo_a, 1);
    vs_pulse();
    chk("ov_xo_a_clr", xo_a, 0);
    chk("ov_yo_a_clr", yo_a, 0);
    chk("ov_xo_b_clr", xo_b, 0);
    chk("ov_yo_b_clr", yo_b, 0);
    chk("ov_y_a_clr", y_a, 0);
    chk("f4_fc_a", fc_a, 4);
    chk("f4_fc_b_wrap", fc_b, 0);

    // VS activation on the same edge dut_a's DVAL would fall.
    run_line(H, 5);
    chk("co_y_a_pre", y_a, 1);
    clr_cnt();
    req = 1'b1;
    repeat (8) step();
    req = 1'b0;
    step();
    step();
    chk("co_dval_a_pre", dval_a, 1);
    chk("co_x_a_pre", x_a, 7);
    vs_a = 1'b0;
    step();
    chk("co_le_a", le_a, 0);
    chk("co_x_a", x_a, 0);
    chk("co_y_a", y_a, 0);
    chk("co_dval_a", dval_a, 0);
    chk("co_fs_a", fs_a, 1);
    chk("f5_fc_b", fc_b, 1);
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("vs_req_dval_a", dval_a, 0);
      chk("vs_req_dval_b", dval_b, 0);
    end
    vs_a = 1'b1;
    req = 1'b0;
    repeat (5) step();
    chk("co_dv_cnt_a", dv_cnt_a, 8);
    chk("co_dv_cnt_b", dv_cnt_b, 8);
    chk("co_le_cnt_a", le_cnt_a, 0);

    // Asynchronous reset mid-line.
    req = 1'b1;
    repeat (8) step();
    chk("mr_x_a", x_a, 5);
    chk("mr_x_b", x_b, 7);
    chk("mr_fc_a", fc_a, 5);
    rst_n = 1'b0;
    #2;
    chk("ar_dval_a", dval_a, 0);
    chk("ar_x_a", x_a, 0);
    chk("ar_fc_a", fc_a, 0);
    chk("ar_dval_b", dval_b, 0);
    chk("ar_x_b", x_b, 0);
    chk("ar_fc_b", fc_b, 0);
    req = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    vs_pulse();
    run_line(H, 5);
    chk("rr_fc_a", fc_a, 1);
    chk("rr_fc_b", fc_b, 1);
    chk("rr_y_a", y_a, 1);
    chk("rr_y_b", y_b, 1);
    chk("rr_x_a", x_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
